// File: rtl/wakeup_broadcaster_pkg.sv
// wakeup_pkg: types shared by the wakeup broadcaster and the issue queues
// that consume its wakeup bus (wakeup_phys is a phys_t on both sides).
package wakeup_pkg;

    localparam int PHYS_W = 6;
    localparam int LAT_W  = 3;

    typedef logic [PHYS_W-1:0] phys_t;
    typedef logic [LAT_W-1:0]  lat_t;

    // One tracked in-flight op: cnt is the number of cycles left before it is due.
    typedef struct packed {
        logic  valid;
        phys_t phys;
        lat_t  cnt;
    } wk_slot_t;

    // Latency 0 behaves like latency 1; the slot counter holds latency-1.
    function automatic lat_t lat_to_cnt(input lat_t lat);
        return (lat == '0) ? '0 : lat - lat_t'(1);
    endfunction

endpackage

// File: rtl/wakeup_broadcaster_if.sv
// wakeup_broadcaster_if: issue-side handshake plus the wakeup broadcast bus.
// master = execute/issue side and wakeup consumers, slave = the broadcaster.
interface wakeup_broadcaster_if #(
    parameter int NUM_SLOTS = 8
);
    import wakeup_pkg::*;

    localparam int OCC_W = $clog2(NUM_SLOTS) + 1;

    logic             issue_valid;
    logic             issue_ready;
    phys_t            issue_phys;
    lat_t             issue_lat;
    logic             flush;
    logic             wakeup_valid;
    phys_t            wakeup_phys;
    logic             busy;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output issue_valid, issue_phys, issue_lat, flush,
        input  issue_ready, wakeup_valid, wakeup_phys, busy, occupancy
    );

    modport slave (
        input  issue_valid, issue_phys, issue_lat, flush,
        output issue_ready, wakeup_valid, wakeup_phys, busy, occupancy
    );

endinterface

// File: rtl/wakeup_broadcaster_rr_arbiter.sv
// wk_rr_arbiter: round-robin grant over a request vector. The search starts
// at i_ptr and wraps; NUM_SLOTS is a power of two so index wrap is free.
module wk_rr_arbiter #(
    parameter int NUM_SLOTS = 8,
    localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_SLOTS-1:0] o_gnt,
    output logic [IDX_W-1:0]     o_gnt_idx,
    output logic                 o_gnt_valid
);

    // First requester at or after the pointer, in circular order.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = i_ptr + IDX_W'(k);
            if (!found && i_req[idx]) begin
                found       = 1'b1;
                o_gnt[idx]  = 1'b1;
                o_gnt_idx   = idx;
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wakeup_broadcaster.sv
// wakeup_broadcaster: tracks issued ops by destination register and
// remaining latency, and broadcasts each one exactly once on the wakeup bus
// when its result is available (one broadcast per cycle, round-robin among
// ops that are due at the same time).
// Optional build macro WAKEUP_PERF_CNT_EN adds broadcast/stall counters.
module wakeup_broadcaster
    import wakeup_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    wakeup_broadcaster_if.slave         bus
`ifdef WAKEUP_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_bcast_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int OCC_W = $clog2(NUM_SLOTS) + 1;

    wk_slot_t         r_slots [NUM_SLOTS];
    logic [IDX_W-1:0] r_ptr;
    logic             r_wk_valid;
    phys_t            r_wk_phys;
    logic [OCC_W-1:0] r_occ;
    logic             r_busy;

    logic [NUM_SLOTS-1:0] w_due;
    logic [NUM_SLOTS-1:0] w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_gnt_valid;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_has_free;
    logic                 w_accept;
    logic                 w_grant;
    logic [OCC_W-1:0]     w_occ_next;

    // A slot is due once its countdown has reached zero; it stays due until granted.
    always_comb begin
        w_due = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_due[i] = r_slots[i].valid && (r_slots[i].cnt == '0);
        end
    end

    // Lowest-index free slot, from registered state only.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slots[i].valid) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    wk_rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_arb (
        .i_req       (w_due),
        .i_ptr       (r_ptr),
        .o_gnt       (w_gnt),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    // Flush drops both the accept and the broadcast of that cycle.
    assign bus.issue_ready = w_has_free & ~rst;
    assign w_accept        = bus.issue_valid & bus.issue_ready & ~bus.flush;
    assign w_grant         = w_gnt_valid & ~bus.flush;
    assign w_occ_next      = bus.flush ? '0
                           : r_occ + OCC_W'(w_accept) - OCC_W'(w_grant);

    // Slot table: release the granted slot, load the accepted op, count down the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_grant && w_gnt[i]) begin
                    r_slots[i].valid <= 1'b0;
                end else if (w_accept && (w_free_idx == IDX_W'(i))) begin
                    r_slots[i].valid <= 1'b1;
                    r_slots[i].phys  <= bus.issue_phys;
                    r_slots[i].cnt   <= lat_to_cnt(bus.issue_lat);
                end else if (r_slots[i].valid && (r_slots[i].cnt != '0)) begin
                    r_slots[i].cnt   <= r_slots[i].cnt - lat_t'(1);
                end
            end
        end
    end

    // Broadcast register and round-robin pointer; wakeup_phys holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wk_valid <= 1'b0;
            r_wk_phys  <= '0;
            r_ptr      <= '0;
        end else begin
            r_wk_valid <= w_grant;
            if (w_grant) begin
                r_wk_phys <= r_slots[w_gnt_idx].phys;
            end
            if (bus.flush) begin
                r_ptr <= '0;
            end else if (w_grant) begin
                r_ptr <= w_gnt_idx + IDX_W'(1);
            end
        end
    end

    // Occupancy tracks the net of accept and grant so it matches the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_occ  <= w_occ_next;
            r_busy <= (w_occ_next != '0);
        end
    end

    assign bus.wakeup_valid = r_wk_valid;
    assign bus.wakeup_phys  = r_wk_phys;
    assign bus.occupancy    = r_occ;
    assign bus.busy         = r_busy;

`ifdef WAKEUP_PERF_CNT_EN
    logic [31:0] r_perf_bcast;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    // A stall is any cycle where some due op is left waiting, including a flush.
    assign w_stall = (|w_due) && (bus.flush || (w_due != w_gnt));

    // Free-running wrap-around counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_bcast <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_grant) begin
                r_perf_bcast <= r_perf_bcast + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_bcast_cnt = r_perf_bcast;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
